// File: rtl/decoder_2to4_pulse_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | decoder_2to4_pulse_pkg                                           |
// | Shared FSM encodings and the code-to-one-hot helper.             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package decoder_2to4_pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  function automatic logic [3:0] onehot4(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_2to4_pulse_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | decoder_2to4_pulse_if                                            |
// | Encoded-code input and one-hot output bundle of the decoder.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface decoder_2to4_pulse_if;
  logic [1:0] Y;
  logic       V;
  logic       ready;
  logic [3:0] D;
  logic       busy;
  logic       drop;

  modport master (output Y, output V, input ready, input D, input busy, input drop);
  modport slave  (input Y, input V, output ready, output D, output busy, output drop);
endinterface
`default_nettype wire

// File: rtl/decoder_2to4_pulse_code_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | code_fifo                                                        |
// | 2-bit first-word-fall-through FIFO holding pending codes.        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module code_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic                          clk,
  input  wire logic                          rst,
  input  wire logic                          push_i,
  input  wire logic                          pop_i,
  input  wire logic [1:0]                    din_i,
  output logic      [1:0]                    dout_o,
  output logic                               empty_o,
  output logic                               full_o,
  output logic      [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [1:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/decoder_2to4_pulse.sv
`default_nettype none
// +------------------------------------------------------------------+
// | decoder_2to4_pulse                                               |
// | Buffers 2-bit codes and replays each as a fixed one-hot pulse.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module decoder_2to4_pulse
  import decoder_2to4_pulse_pkg::*;
#(
  parameter int PULSE_LEN  = 4,
  parameter int GAP_LEN    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input wire logic            clk,
  input wire logic            rst,
  decoder_2to4_pulse_if.slave dec
);

  localparam int CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] c_PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] c_GAP_LAST   = CNT_W'(GAP_LEN - 1);

  state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] d_q, d_d;
  logic       drop_q;

  logic       w_ready;
  logic       w_push;
  logic       w_pop;
  logic [1:0] w_head;
  logic       w_empty;
  logic       w_full;
  logic [$clog2(FIFO_DEPTH):0] w_count;

  code_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .din_i   (dec.Y),
    .dout_o  (w_head),
    .empty_o (w_empty),
    .full_o  (w_full),
    .count_o (w_count)
  );

  assign w_ready   = !w_full;
  assign w_push    = dec.V && w_ready;
  assign dec.ready = w_ready;
  assign dec.D     = d_q;
  assign dec.drop  = drop_q;
  assign dec.busy  = (state_q != ST_IDLE) || (w_count != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    w_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        d_d = 4'b0000;
        if (!w_empty) begin
          w_pop   = 1'b1;
          d_d     = onehot4(w_head);
          cnt_d   = c_PULSE_LAST;
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          d_d     = 4'b0000;
          cnt_d   = c_GAP_LAST;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        d_d = 4'b0000;
        if (cnt_q == '0) begin
          // End of gap chains straight into the next buffered code.
          if (!w_empty) begin
            w_pop   = 1'b1;
            d_d     = onehot4(w_head);
            cnt_d   = c_PULSE_LAST;
            state_d = ST_PULSE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        d_d     = 4'b0000;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      d_q     <= 4'b0000;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      drop_q  <= dec.V && !w_ready;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decoder_2to4_pulse.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_decoder_2to4_pulse                                            |
// | Scoreboard bench: queued codes replayed against a timeline model.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_decoder_2to4_pulse;
  import decoder_2to4_pulse_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decoder_2to4_pulse_if bus_a ();
  decoder_2to4_pulse_if bus_b ();

  decoder_2to4_pulse #(.PULSE_LEN(4), .GAP_LEN(1), .FIFO_DEPTH(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .dec (bus_a)
  );

  decoder_2to4_pulse #(.PULSE_LEN(1), .GAP_LEN(3), .FIFO_DEPTH(4)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .dec (bus_b)
  );

  int         total;
  int         bad;
  int         sel;
  int         p_len;
  int         g_len;
  int         edge_n;
  int         next_free;
  int         d_left;
  int         dut_pulses;
  logic [1:0] d_code;
  logic [3:0] prev_d;
  logic [1:0] sb_q[$];

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] cur_d();
    return (sel != 0) ? bus_b.D : bus_a.D;
  endfunction
  function automatic logic cur_ready();
    return (sel != 0) ? bus_b.ready : bus_a.ready;
  endfunction
  function automatic logic cur_busy();
    return (sel != 0) ? bus_b.busy : bus_a.busy;
  endfunction
  function automatic logic cur_drop();
    return (sel != 0) ? bus_b.drop : bus_a.drop;
  endfunction

  // One clock: drive at the falling edge, predict the next rising edge, check afterwards.
  task automatic cycle(input logic v, input logic [1:0] y);
    logic       ready_e;
    logic       pop_e;
    logic       drop_e;
    logic       busy_e;
    logic [3:0] d_e;
    logic [3:0] got_d;
    if (sel != 0) begin bus_b.V = v; bus_b.Y = y; end
    else          begin bus_a.V = v; bus_a.Y = y; end
    ready_e = (sb_q.size() < 4);
    #1;
    chk("ready", {3'b0, cur_ready()}, {3'b0, ready_e});
    pop_e = (sb_q.size() > 0) && (edge_n >= next_free);
    if (pop_e) begin
      d_code    = sb_q.pop_front();
      d_left    = p_len;
      next_free = edge_n + p_len + g_len;
    end else if (d_left > 0) begin
      d_left--;
    end
    if (v && ready_e) sb_q.push_back(y);
    drop_e = v && !ready_e;
    busy_e = (edge_n < next_free) || (sb_q.size() > 0);
    d_e    = (d_left > 0) ? onehot4(d_code) : 4'b0000;
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    got_d = cur_d();
    chk("D", got_d, d_e);
    chk("drop", {3'b0, cur_drop()}, {3'b0, drop_e});
    chk("busy", {3'b0, cur_busy()}, {3'b0, busy_e});
    if (got_d != 4'b0000 && prev_d == 4'b0000) dut_pulses++;
    prev_d = got_d;
  endtask

  // Called at a falling edge; reset is raised mid-cycle to expose its asynchronous effect.
  task automatic do_reset(input int new_sel, input int new_p, input int new_g);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_D", cur_d(), 4'b0000);
    chk("rst_busy", {3'b0, cur_busy()}, 4'b0000);
    chk("rst_ready", {3'b0, cur_ready()}, 4'b0001);
    chk("rst_drop", {3'b0, cur_drop()}, 4'b0000);
    bus_a.V = 1'b0; bus_a.Y = 2'b00;
    bus_b.V = 1'b0; bus_b.Y = 2'b00;
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    rst       = 1'b0;
    sel       = new_sel;
    p_len     = new_p;
    g_len     = new_g;
    sb_q.delete();
    d_left    = 0;
    next_free = edge_n;
    prev_d    = 4'b0000;
  endtask

  initial begin
    total = 0; bad = 0; edge_n = 0; next_free = 0; d_left = 0;
    d_code = 2'b00; prev_d = 4'b0000; dut_pulses = 0;
    sel = 0; p_len = 4; g_len = 1;
    rst = 1'b1;
    bus_a.V = 1'b0; bus_a.Y = 2'b00;
    bus_b.V = 1'b0; bus_b.Y = 2'b00;
    @(negedge clk);
    do_reset(0, 4, 1);

    // Single code
    dut_pulses = 0;
    cycle(1'b1, 2'd2);
    repeat (8) cycle(1'b0, 2'd0);
    chk("t1_pulses", 4'(dut_pulses), 4'd1);

    // Burst 0,1,3
    dut_pulses = 0;
    cycle(1'b1, 2'd0);
    cycle(1'b1, 2'd1);
    cycle(1'b1, 2'd3);
    repeat (16) cycle(1'b0, 2'd0);
    chk("t2_pulses", 4'(dut_pulses), 4'd3);

    // Overflow: six pushes of code 1
    dut_pulses = 0;
    repeat (6) cycle(1'b1, 2'd1);
    repeat (28) cycle(1'b0, 2'd0);
    chk("t3_pulses", 4'(dut_pulses), 4'd5);

    // Keep the FIFO saturated while the FSM pops
    dut_pulses = 0;
    for (int i = 0; i < 14; i++) cycle(1'b1, 2'(i % 4));
    repeat (45) cycle(1'b0, 2'd0);
    chk("t4_empty", {3'b0, cur_busy()}, 4'b0000);

    // Reset during the second cycle of a 1000 pulse with two codes queued
    dut_pulses = 0;
    cycle(1'b1, 2'd3);
    cycle(1'b1, 2'd1);
    cycle(1'b1, 2'd2);
    do_reset(0, 4, 1);
    repeat (12) cycle(1'b0, 2'd0);
    chk("t5_pulses", 4'(dut_pulses), 4'd1);

    // Short pulse, long gap variant
    do_reset(1, 1, 3);
    dut_pulses = 0;
    cycle(1'b1, 2'd2);
    cycle(1'b1, 2'd2);
    repeat (8) cycle(1'b0, 2'd0);
    chk("t6_pulses", 4'(dut_pulses), 4'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
